// File: rtl/vc_arb_client.sv
// vc_arb_client: client side of a variable-priority arbitration chain.
//
// Each input port owns a one-entry holding register. Occupied entries are
// presented to an external arbitration chain as requests together with a
// one-hot priority vector. The chain returns a grant vector combinationally.
// The granted entry is forwarded downstream and freed when downstream accepts.
// Priority then rotates to the port just after the winner.
//
// Ports:
//   clk_i        clock; all state updates on the rising edge
//   reset_i      synchronous active-high reset
//   domain_i     security-domain label {L}; carries no functional logic
//   in_val_i     per-port message valid
//   in_rdy_o     per-port ready (entry empty)
//   in_msg_i     per-port messages, port i in bits [i*M +: M]
//   reqs_o       request vector to the arbitration chain (= occupied entries)
//   priority_o   one-hot highest-priority port for the chain
//   grants_i     grant vector returned by the chain
//   out_val_o    forwarded message valid
//   out_rdy_i    downstream accepts the forwarded message
//   out_msg_o    forwarded message (OR of granted entries)
//   out_grant_o  one-hot source port of out_msg_o
//   err_o        sticky protocol error (multi-hot or stray grant)

module vc_arb_client #(
  parameter int unsigned p_num_reqs  = 4,
  parameter int unsigned p_msg_nbits = 8
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              domain_i,

  input  logic [p_num_reqs-1:0]             in_val_i,
  output logic [p_num_reqs-1:0]             in_rdy_o,
  input  logic [p_num_reqs*p_msg_nbits-1:0] in_msg_i,

  output logic [p_num_reqs-1:0]             reqs_o,
  output logic [p_num_reqs-1:0]             priority_o,
  input  logic [p_num_reqs-1:0]             grants_i,

  output logic                              out_val_o,
  input  logic                              out_rdy_i,
  output logic [p_msg_nbits-1:0]            out_msg_o,
  output logic [p_num_reqs-1:0]             out_grant_o,

  output logic                              err_o
);

  localparam int unsigned N = p_num_reqs;
  localparam int unsigned M = p_msg_nbits;

  localparam logic [N-1:0] OneN  = N'(1);
  localparam logic [N-1:0] ZeroN = '0;

  // Domain is a static security label only; nothing in the datapath depends on it.
  logic unused_domain;
  assign unused_domain = domain_i;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [N-1:0] full_q, full_d;
  logic [M-1:0] msg_q [N];
  logic [N-1:0] prio_q, prio_d;
  logic         err_q,  err_d;

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  logic [N-1:0] enq;
  logic [N-1:0] eg;
  logic         fire;
  logic         eg_onehot;
  logic         grant_multi;
  logic         grant_stray;

  // Readiness depends only on local state, so no path from out_rdy_i/grants_i.
  assign in_rdy_o = ~full_q;
  assign enq      = in_val_i & ~full_q;

  assign reqs_o     = full_q;
  assign priority_o = prio_q;

  // Grants to empty entries are ignored for forwarding but still flagged.
  assign eg          = grants_i & full_q;
  assign out_val_o   = |eg;
  assign out_grant_o = eg;
  assign fire        = out_val_o & out_rdy_i;

  // x & (x-1) clears the lowest set bit; zero result means at most one bit set.
  assign eg_onehot   = (eg != ZeroN) && ((eg & (eg - OneN)) == ZeroN);
  assign grant_multi = (grants_i & (grants_i - OneN)) != ZeroN;
  assign grant_stray = (grants_i & ~full_q) != ZeroN;

  // Masked OR; yields zero when nothing is granted.
  always_comb begin
    out_msg_o = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (eg[i]) begin
        out_msg_o = out_msg_o | msg_q[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    full_d = full_q;
    prio_d = prio_q;
    err_d  = err_q;

    // Dequeue and enqueue never target the same port: eg is a subset of
    // full_q while enq is a subset of ~full_q.
    if (fire) begin
      full_d = full_d & ~eg;
    end
    full_d = full_d | enq;

    // Rotate the single winner up by one; a multi-hot fire leaves priority alone.
    if (fire && eg_onehot) begin
      prio_d = {eg[N-2:0], eg[N-1]};
    end

    if (grant_multi || grant_stray) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      full_q <= '0;
      prio_q <= OneN;
      err_q  <= 1'b0;
    end else begin
      full_q <= full_d;
      prio_q <= prio_d;
      err_q  <= err_d;
    end
  end

  // Payload needs no reset: it is only observed while its full bit is set.
  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < N; i++) begin
      if (enq[i]) begin
        msg_q[i] <= in_msg_i[i*M +: M];
      end
    end
  end

  assign err_o = err_q;

endmodule
